// File: rtl/mm_ctrl_pkg.sv
// Shared types and constants for the host-side RAM/accelerator sequencer.
package mm_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RX    = 4'd0,
        ST_WRAB  = 4'd1,
        ST_LDMAT = 4'd2,
        ST_START = 4'd3,
        ST_WAIT  = 4'd4,
        ST_WRRES = 4'd5,
        ST_RDRES = 4'd6,
        ST_CAPT  = 4'd7,
        ST_TX    = 4'd8
    } state_t;

    localparam int FRAME_BYTES = 8;
    localparam int RES_BYTES   = 4;

    // Word slots of the operand/result RAM
    localparam int WORD_A   = 0;
    localparam int WORD_B   = 1;
    localparam int WORD_RES = 2;

endpackage

// File: rtl/word_tx_ser.sv
// Serializes a 32-bit word into RES_BYTES bytes, MSB first, over valid/ready.
// o_done pulses combinationally with the final accept so the caller can leave
// its wait state on the same edge the last byte is taken.
module word_tx_ser
    import mm_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_done
);

    logic [31:0] r_shift;
    logic [1:0]  r_left;
    logic        r_valid;

    // Load the word, then shift one byte out per accepted transfer
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_shift <= '0;
            r_left  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_left  <= 2'(RES_BYTES - 1);
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            if (r_left == 2'd0) begin
                r_valid <= 1'b0;
                r_shift <= '0;
            end else begin
                r_shift <= {r_shift[23:0], 8'h00};
                r_left  <= r_left - 2'd1;
            end
        end
    end

    assign o_data  = r_shift[31:24];
    assign o_valid = r_valid;
    assign o_done  = r_valid && i_ready && (r_left == 2'd0);

endmodule

// File: rtl/ram_host_seq.sv
// Host sequencer: UART bytes -> X/Y operands in RAM -> accelerator run ->
// result committed to RAM -> result word read back and sent to UART.
//
// state  | meaning
// RX     | collect 8 frame bytes, drop partial frame on inter-byte gap
// WRAB   | write X/Y into RAM (cs/write/utrig)
// LDMAT  | load accelerator operands from RAM (cs/read/read4mat)
// START  | one-cycle mm_start, timeout counter armed
// WAIT   | wait for mm_done or timeout
// WRRES  | commit accelerator result to RAM (cs/write/trig)
// RDRES  | read result word (cs/read/read4c)
// CAPT   | result on read port, loaded into serializer
// TX     | serializer sends 4 bytes, back to RX on done
module ram_host_seq
    import mm_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int RX_GAP  = 65535
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_ram_cs,
    output logic        o_ram_read,
    output logic        o_ram_read4mat,
    output logic        o_ram_read4c,
    output logic        o_ram_write,
    output logic        o_ram_trig,
    output logic        o_ram_utrig,
    output logic [31:0] o_ram_x,
    output logic [31:0] o_ram_y,
    input  logic [31:0] i_ram_res_to_c,
    output logic        o_mm_start,
    input  logic        i_mm_done,
    output logic        o_busy,
    output logic        o_err_timeout,
    output logic        o_rx_overrun
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(RX_GAP + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RX_GAP - 1);

    state_t           r_state;
    logic [2:0]       r_byte_cnt;
    logic [55:0]      r_asm;
    logic [GAP_W-1:0] r_gap;
    logic [TMO_W-1:0] r_tmo;
    logic             r_cs;
    logic             r_read;
    logic             r_read4mat;
    logic             r_read4c;
    logic             r_write;
    logic             r_trig;
    logic             r_utrig;
    logic [31:0]      r_ram_x;
    logic [31:0]      r_ram_y;
    logic             r_mm_start;
    logic             r_busy;
    logic             r_err_timeout;
    logic             r_rx_overrun;

    logic [63:0]      w_frame;
    logic             w_gap_expired;
    logic             w_ser_load;
    logic             w_ser_done;

    // Incoming byte appended to the bytes already collected (big-endian)
    assign w_frame       = {r_asm, i_rx_data};
    assign w_gap_expired = (r_byte_cnt != 3'd0) && (r_gap == '0);
    assign w_ser_load    = (r_state == ST_CAPT);

    // Sequencer FSM with registered RAM strobes and status outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_RX;
            r_byte_cnt    <= '0;
            r_asm         <= '0;
            r_gap         <= '0;
            r_tmo         <= '0;
            r_cs          <= 1'b0;
            r_read        <= 1'b0;
            r_read4mat    <= 1'b0;
            r_read4c      <= 1'b0;
            r_write       <= 1'b0;
            r_trig        <= 1'b0;
            r_utrig       <= 1'b0;
            r_ram_x       <= '0;
            r_ram_y       <= '0;
            r_mm_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_rx_overrun  <= 1'b0;
        end else begin
            r_cs       <= 1'b0;
            r_read     <= 1'b0;
            r_read4mat <= 1'b0;
            r_read4c   <= 1'b0;
            r_write    <= 1'b0;
            r_trig     <= 1'b0;
            r_utrig    <= 1'b0;
            r_mm_start <= 1'b0;

            if (i_rx_valid && (r_state != ST_RX)) begin
                r_rx_overrun <= 1'b1;
            end

            case (r_state)
                ST_RX: begin
                    if (i_rx_valid) begin
                        r_asm <= w_frame[55:0];
                        r_gap <= GAP_LOAD;
                        if (w_gap_expired) begin
                            // stale partial frame dropped, this byte starts a new one
                            r_byte_cnt <= 3'd1;
                        end else if (r_byte_cnt == 3'(FRAME_BYTES - 1)) begin
                            r_byte_cnt <= '0;
                            r_ram_x    <= w_frame[63:32];
                            r_ram_y    <= w_frame[31:0];
                            r_cs       <= 1'b1;
                            r_write    <= 1'b1;
                            r_utrig    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= ST_WRAB;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end else if (r_byte_cnt != 3'd0) begin
                        if (r_gap == '0) begin
                            r_byte_cnt <= '0;
                        end else begin
                            r_gap <= r_gap - 1'b1;
                        end
                    end
                end
                ST_WRAB: begin
                    r_cs       <= 1'b1;
                    r_read     <= 1'b1;
                    r_read4mat <= 1'b1;
                    r_state    <= ST_LDMAT;
                end
                ST_LDMAT: begin
                    r_mm_start <= 1'b1;
                    r_tmo      <= TMO_LOAD;
                    r_state    <= ST_START;
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_mm_done) begin
                        r_cs    <= 1'b1;
                        r_write <= 1'b1;
                        r_trig  <= 1'b1;
                        r_state <= ST_WRRES;
                    end else if (r_tmo == '0) begin
                        r_err_timeout <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_RX;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                ST_WRRES: begin
                    r_cs     <= 1'b1;
                    r_read   <= 1'b1;
                    r_read4c <= 1'b1;
                    r_state  <= ST_RDRES;
                end
                ST_RDRES: begin
                    r_state <= ST_CAPT;
                end
                ST_CAPT: begin
                    r_state <= ST_TX;
                end
                ST_TX: begin
                    if (w_ser_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_RX;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_RX;
                end
            endcase
        end
    end

    word_tx_ser u_tx_ser (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_ser_load),
        .i_word  (i_ram_res_to_c),
        .i_ready (i_tx_ready),
        .o_data  (o_tx_data),
        .o_valid (o_tx_valid),
        .o_done  (w_ser_done)
    );

    assign o_ram_cs       = r_cs;
    assign o_ram_read     = r_read;
    assign o_ram_read4mat = r_read4mat;
    assign o_ram_read4c   = r_read4c;
    assign o_ram_write    = r_write;
    assign o_ram_trig     = r_trig;
    assign o_ram_utrig    = r_utrig;
    assign o_ram_x        = r_ram_x;
    assign o_ram_y        = r_ram_y;
    assign o_mm_start     = r_mm_start;
    assign o_busy         = r_busy;
    assign o_err_timeout  = r_err_timeout;
    assign o_rx_overrun   = r_rx_overrun;

endmodule
